mixcolumns: RTL and testbench

Column-serial AES MixColumns stage that directly consumes the 128-bit state produced by the ShiftRows stage and feeds AddRoundKey. It captures one state on an `ena` strobe, transforms one 32-bit column per clock over four cycles, then presents the full result with a one-cycle `done` pulse. This trades three extra cycles for a single shared column datapath.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/mixcolumn_word.sv | 74 +++++++
 rtl/mixcolumns.sv | 85 ++++++++
 tb/tb_mixcolumns.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the column-serial MixColumns stage.
// The INV_MIXCOLUMNS_EN macro is consumed by mixcolumns and mixcolumn_word, not here.
package aes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

    localparam logic [7:0] AES_POLY = 8'h1b;

    localparam int BYTE_W   = 8;
    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;
    localparam int STATE_W  = COL_W * NUM_COLS;

    localparam logic [1:0] LAST_COL = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// Combinational MixColumns transform of one 32-bit column (byte r at bits [8r+7:8r]).
// With INV_MIXCOLUMNS_EN defined an inv input selects InvMixColumns.
module mixcolumn_word
    import aes_pkg::*;
(
`ifdef INV_MIXCOLUMNS_EN
    input  logic             inv,
`endif
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [BYTE_W-1:0] a  [NUM_COLS];
    logic [BYTE_W-1:0] x2 [NUM_COLS];
    logic [BYTE_W-1:0] fwd [NUM_COLS];

    always_comb begin
        for (int r = 0; r < NUM_COLS; r++) begin
            a[r]  = col_in[r*BYTE_W +: BYTE_W];
            x2[r] = xtime(a[r]);
        end
    end

    // 3x is folded in as (2x ^ x)
    always_comb begin
        fwd[0] = x2[0] ^ (x2[1] ^ a[1]) ^ a[2] ^ a[3];
        fwd[1] = a[0] ^ x2[1] ^ (x2[2] ^ a[2]) ^ a[3];
        fwd[2] = a[0] ^ a[1] ^ x2[2] ^ (x2[3] ^ a[3]);
        fwd[3] = (x2[0] ^ a[0]) ^ a[1] ^ a[2] ^ x2[3];
    end

`ifdef INV_MIXCOLUMNS_EN
    logic [BYTE_W-1:0] x4 [NUM_COLS];
    logic [BYTE_W-1:0] x8 [NUM_COLS];
    logic [BYTE_W-1:0] m9 [NUM_COLS];
    logic [BYTE_W-1:0] mb [NUM_COLS];
    logic [BYTE_W-1:0] md [NUM_COLS];
    logic [BYTE_W-1:0] me [NUM_COLS];
    logic [BYTE_W-1:0] rev [NUM_COLS];

    always_comb begin
        for (int r = 0; r < NUM_COLS; r++) begin
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    always_comb begin
        rev[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        rev[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        rev[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        rev[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < NUM_COLS; r++) begin
            col_out[r*BYTE_W +: BYTE_W] = inv ? rev[r] : fwd[r];
        end
    end
`else
    always_comb begin
        col_out = '0;
        for (int r = 0; r < NUM_COLS; r++) begin
            col_out[r*BYTE_W +: BYTE_W] = fwd[r];
        end
    end
`endif

endmodule

// File: rtl/mixcolumns.sv
// Column-serial AES MixColumns: captures a state on ena, transforms one column per clock, pulses done.
// Defining INV_MIXCOLUMNS_EN adds the inv port and the inverse transform.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for ena; state_out holds the last result
// ST_BUSY | transforming column col of the captured state, 0..3
module mixcolumns
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [STATE_W-1:0] state_in,
`ifdef INV_MIXCOLUMNS_EN
    input  logic               inv,
`endif
    output logic [STATE_W-1:0] state_out,
    output logic               done,
    output logic               busy
);

    mc_state_t          state;
    logic [1:0]         col;
    logic [STATE_W-1:0] work;
    logic [STATE_W-1:0] result;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;

`ifdef INV_MIXCOLUMNS_EN
    logic inv_q;
`endif

    assign col_in = work[{col, 5'd0} +: COL_W];

    mixcolumn_word u_word (
`ifdef INV_MIXCOLUMNS_EN
        .inv     (inv_q),
`endif
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            col       <= 2'd0;
            work      <= '0;
            result    <= '0;
            state_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef INV_MIXCOLUMNS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ena) begin
                        work  <= state_in;
`ifdef INV_MIXCOLUMNS_EN
                        inv_q <= inv;
`endif
                        col   <= 2'd0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result[{col, 5'd0} +: COL_W] <= col_out;
                    col <= col + 2'd1;
                    if (col == LAST_COL) begin
                        // column 3 is not in result yet, so splice it in directly
                        state_out <= {col_out, result[3*COL_W-1:0]};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumns.sv
// Directed self-checking bench for mixcolumns (forward; inverse too when INV_MIXCOLUMNS_EN is defined).
module tb_mixcolumns;

    localparam logic [127:0] V0 = 128'h4c31262d_01010101_5c220af2_455313db;
    localparam logic [127:0] E0 = 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] V1 = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
    localparam logic [127:0] E1 = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
    localparam logic [127:0] V2 = 128'hc6c6c6c6_d5d4d4d4_01010101_455313db;
    localparam logic [127:0] E2 = 128'hc6c6c6c6_d6d7d5d5_01010101_bca14d8e;
    localparam logic [127:0] V3 = 128'h0;
    localparam logic [127:0] E3 = 128'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         done;
    logic         busy;
`ifdef INV_MIXCOLUMNS_EN
    logic         inv;
`endif

    int checks = 0;
    int errors = 0;
    logic [127:0] last_exp = '0;

    always #5 clk = ~clk;

    mixcolumns dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .state_in  (state_in),
`ifdef INV_MIXCOLUMNS_EN
        .inv       (inv),
`endif
        .state_out (state_out),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Capture din, keep ena high through BUSY (must be ignored), scramble state_in after capture.
    task automatic run_op(input logic [127:0] din, input logic [127:0] exp,
                          input logic inv_sel, input logic hold_ena);
        state_in = din;
        ena      = 1'b1;
`ifdef INV_MIXCOLUMNS_EN
        inv      = inv_sel;
`else
        if (inv_sel) $display("note: inverse requested without INV_MIXCOLUMNS_EN");
`endif
        tick;
        state_in = ~din;
`ifdef INV_MIXCOLUMNS_EN
        inv      = ~inv_sel;
`endif
        for (int k = 0; k < 4; k++) begin
            check("busy_run", 128'(busy), 128'd1);
            check("done_early", 128'(done), 128'd0);
            check("out_hold", state_out, last_exp);
            if (k < 3) tick;
        end
        ena = hold_ena;
        tick;
        check("done_pulse", 128'(done), 128'd1);
        check("busy_end", 128'(busy), 128'd0);
        check("result", state_out, exp);
        last_exp = exp;
        if (!hold_ena) begin
            tick;
            check("done_clear", 128'(done), 128'd0);
            check("idle_busy", 128'(busy), 128'd0);
            check("result_hold", state_out, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        ena      = 1'b0;
        state_in = '0;
`ifdef INV_MIXCOLUMNS_EN
        inv      = 1'b0;
`endif
        #12;
        check("rst_out", state_out, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check("idle_busy0", 128'(busy), 128'd0);

        run_op(V0, E0, 1'b0, 1'b0);
        run_op(V1, E1, 1'b0, 1'b0);

        run_op(V3, E3, 1'b0, 1'b1);
        run_op(V2, E2, 1'b0, 1'b1);
        run_op(V0, E0, 1'b0, 1'b0);

        // abort during the third BUSY cycle
        state_in = V1;
        ena      = 1'b1;
        tick;
        ena = 1'b0;
        tick;
        tick;
        check("pre_abort_busy", 128'(busy), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_out", state_out, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            check("no_done_after_abort", 128'(done), 128'd0);
            check("no_busy_after_abort", 128'(busy), 128'd0);
        end
        last_exp = '0;
        run_op(V1, E1, 1'b0, 1'b0);

`ifdef INV_MIXCOLUMNS_EN
        run_op(E0, V0, 1'b1, 1'b0);
        run_op(E1, V1, 1'b1, 1'b1);
        run_op(V2, E2, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
